// File: rtl/cb_dinb_mapper_pkg.sv
// Mode encodings and the lane-mapping function shared by the CB port-B write-data mapper.
// Lanes are passed at a fixed MAX_DW stride so one function serves every X/L/RSA_DW combination.
package cb_dinb_pkg;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_POS  = 2'd1;
    localparam logic [1:0] MODE_NEG  = 2'd2;
    localparam logic [1:0] MODE_NEW  = 2'd3;

    localparam int MAX_LANES = 16;
    localparam int MAX_DW    = 32;

    typedef struct packed {
        logic [MAX_LANES-1:0]        en;
        logic [MAX_LANES*MAX_DW-1:0] data;
    } lane_map_t;

    function automatic lane_map_t map_lanes(input logic [1:0] mode, input int slot,
                                            input logic [MAX_LANES*MAX_DW-1:0] data,
                                            input int x, input int l, input int new_lanes);
        lane_map_t r;
        int src;
        r = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            src = -1;
            if (k < l) begin
                case (mode)
                    MODE_POS: if (k < x) src = k;
                    MODE_NEG: if (l - 1 - k < x) src = l - 1 - k;
                    MODE_NEW: if (slot < l / new_lanes && k >= slot * new_lanes &&
                                  k < (slot + 1) * new_lanes) src = k - slot * new_lanes;
                    default:  src = -1;
                endcase
            end
            // an out-of-range NEW slot leaves every lane zero with its enable cleared
            if (src >= 0) begin
                r.en[k] = 1'b1;
                r.data[k*MAX_DW +: MAX_DW] = data[src*MAX_DW +: MAX_DW];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cb_dinb_mapper_if.sv
// Handshake and control bundle between the RSA C-output collector and the CB port-B mapper.
// out_lane_en exists only when CB_DINB_LANE_MASK_EN is defined.
interface cb_dinb_mapper_if #(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int SLOT_W = 1
);
    logic [1:0]          mode_sel;
    logic [SLOT_W-1:0]   new_slot;
    logic                row_clr;
    logic                in_valid;
    logic                in_ready;
    logic [X*RSA_DW-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [L*RSA_DW-1:0] out_data;
    logic                out_last;
`ifdef CB_DINB_LANE_MASK_EN
    logic [L-1:0]        out_lane_en;

    modport master (output mode_sel, new_slot, row_clr, in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_last, out_lane_en);
    modport slave  (input  mode_sel, new_slot, row_clr, in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_last, out_lane_en);
`else
    modport master (output mode_sel, new_slot, row_clr, in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_last);
    modport slave  (input  mode_sel, new_slot, row_clr, in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_last);
`endif
endinterface

// File: rtl/cb_dinb_mapper_skid.sv
// One-entry valid/ready skid buffer; the output register is the first stage, the skid the second.
// push_ready is its own flop and is low exactly while the skid entry is occupied.
module cb_dinb_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);
    logic [W-1:0] skid_data;
    logic         accept;

    assign accept = push_valid & push_ready;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            pop_valid  <= 1'b0;
            pop_data   <= '0;
            push_ready <= 1'b1;
            skid_data  <= '0;
        end else if (!pop_valid || pop_ready) begin
            if (!push_ready) begin
                pop_valid  <= 1'b1;
                pop_data   <= skid_data;
                push_ready <= 1'b1;
            end else begin
                pop_valid <= accept;
                if (accept) pop_data <= push_data;
            end
        end else if (accept) begin
            skid_data  <= push_data;
            push_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/cb_dinb_mapper.sv
// CB port-B write-data mapper: lane mapping, row-beat counter and a skid-buffered handshake.
// Per-lane write enables are added when CB_DINB_LANE_MASK_EN is defined.
module cb_dinb_mapper
    import cb_dinb_pkg::*;
#(
    parameter int X         = 4,
    parameter int L         = 4,
    parameter int RSA_DW    = 16,
    parameter int NEW_LANES = 2,
    parameter int ROW_LEN   = 10
) (
    input logic             clk,
    input logic             sys_rst,
    cb_dinb_mapper_if.slave bus
);
    localparam int SLOT_W = (L / NEW_LANES > 1) ? $clog2(L / NEW_LANES) : 1;
    localparam int CW     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ROW_LEN - 1);
`ifdef CB_DINB_LANE_MASK_EN
    localparam int PW = 1 + L + L * RSA_DW;
`else
    localparam int PW = 1 + L * RSA_DW;
`endif

    logic [MAX_LANES*MAX_DW-1:0] in_wide;
    lane_map_t                   mapped;
    logic [L*RSA_DW-1:0]         map_data;
    logic [SLOT_W-1:0]           slot;
    logic [CW-1:0]               row_cnt;
    logic [CW-1:0]               beat_idx;
    logic                        beat_last;
    logic                        accept;
    logic [PW-1:0]               push_data;
    logic [PW-1:0]               pop_data;
    logic                        unused_map;

    always_comb begin
        in_wide = '0;
        for (int i = 0; i < X; i++) in_wide[i*MAX_DW +: RSA_DW] = bus.in_data[i*RSA_DW +: RSA_DW];
    end

    assign slot   = bus.new_slot;
    assign mapped = map_lanes(bus.mode_sel, int'(slot), in_wide, X, L, NEW_LANES);

    always_comb begin
        map_data = '0;
        for (int k = 0; k < L; k++) map_data[k*RSA_DW +: RSA_DW] = mapped.data[k*MAX_DW +: RSA_DW];
    end

    assign unused_map = ^mapped;

    // row_clr coinciding with an accept makes that beat index 0
    assign accept    = bus.in_valid & bus.in_ready;
    assign beat_idx  = bus.row_clr ? '0 : row_cnt;
    assign beat_last = (beat_idx == LAST_IDX);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)          row_cnt <= '0;
        else if (accept)      row_cnt <= beat_last ? '0 : beat_idx + 1'b1;
        else if (bus.row_clr) row_cnt <= '0;
    end

`ifdef CB_DINB_LANE_MASK_EN
    assign push_data = {beat_last, mapped.en[L-1:0], map_data};
    assign {bus.out_last, bus.out_lane_en, bus.out_data} = pop_data;
`else
    assign push_data = {beat_last, map_data};
    assign {bus.out_last, bus.out_data} = pop_data;
`endif

    cb_dinb_skid #(.W(PW)) u_skid (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .push_valid (bus.in_valid),
        .push_ready (bus.in_ready),
        .push_data  (push_data),
        .pop_valid  (bus.out_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (pop_data)
    );

endmodule

// File: tb/tb_cb_dinb_mapper.sv
// Scoreboard bench for cb_dinb_mapper: main X=L=4 instance plus X=2, X=6 and L=6 sweep instances.
// Lane enables are compared only when CB_DINB_LANE_MASK_EN is defined.
module tb_cb_dinb_mapper;
    localparam int DW = 16;
    localparam int NL = 2;
    localparam int RL = 10;

    typedef struct packed { logic [5:0] en; logic [95:0] data; } model_t;
    typedef struct { logic [63:0] data; logic last; logic [3:0] en; } exp_t;
    typedef struct { logic [95:0] data; logic [5:0] en; } sexp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   row_cnt = 0;
    exp_t  q[$];
    sexp_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    cb_dinb_mapper_if #(.X(4), .L(4), .RSA_DW(DW), .SLOT_W(1)) bus ();
    cb_dinb_mapper_if #(.X(2), .L(4), .RSA_DW(DW), .SLOT_W(1)) bus_a ();
    cb_dinb_mapper_if #(.X(6), .L(4), .RSA_DW(DW), .SLOT_W(1)) bus_b ();
    cb_dinb_mapper_if #(.X(4), .L(6), .RSA_DW(DW), .SLOT_W(2)) bus_c ();

    cb_dinb_mapper #(.X(4), .L(4), .RSA_DW(DW), .NEW_LANES(NL), .ROW_LEN(RL)) dut (
        .clk(clk), .sys_rst(sys_rst), .bus(bus));
    cb_dinb_mapper #(.X(2), .L(4), .RSA_DW(DW), .NEW_LANES(NL), .ROW_LEN(RL)) dut_a (
        .clk(clk), .sys_rst(sys_rst), .bus(bus_a));
    cb_dinb_mapper #(.X(6), .L(4), .RSA_DW(DW), .NEW_LANES(NL), .ROW_LEN(RL)) dut_b (
        .clk(clk), .sys_rst(sys_rst), .bus(bus_b));
    cb_dinb_mapper #(.X(4), .L(6), .RSA_DW(DW), .NEW_LANES(NL), .ROW_LEN(RL)) dut_c (
        .clk(clk), .sys_rst(sys_rst), .bus(bus_c));

    logic [3:0] en_main, en_a, en_b;
    logic [5:0] en_c;
`ifdef CB_DINB_LANE_MASK_EN
    assign en_main = bus.out_lane_en;
    assign en_a    = bus_a.out_lane_en;
    assign en_b    = bus_b.out_lane_en;
    assign en_c    = bus_c.out_lane_en;
`else
    assign en_main = '0;
    assign en_a    = '0;
    assign en_b    = '0;
    assign en_c    = '0;
`endif

    function automatic logic [5:0] keep_en(input logic [5:0] en);
`ifdef CB_DINB_LANE_MASK_EN
        return en;
`else
        return 6'b0;
`endif
    endfunction

    // Walks input lanes and places each at its destination output lane.
    function automatic model_t model_map(input logic [1:0] mode, input int slot,
                                         input logic [95:0] din, input int x, input int l);
        model_t r;
        int dest;
        r = '0;
        for (int j = 0; j < x; j++) begin
            dest = -1;
            if (mode == 2'd1 && j < l) dest = j;
            if (mode == 2'd2 && j < l) dest = l - 1 - j;
            if (mode == 2'd3 && j < NL && slot < l / NL) dest = slot * NL + j;
            if (dest >= 0) begin
                r.en[dest] = 1'b1;
                r.data[dest*16 +: 16] = din[j*16 +: 16];
            end
        end
        return r;
    endfunction

    task automatic push_main();
        exp_t e;
        model_t m;
        int idx;
        if (bus.in_valid && bus.in_ready) begin
            m = model_map(bus.mode_sel, int'(bus.new_slot), {32'b0, bus.in_data}, 4, 4);
            idx = bus.row_clr ? 0 : row_cnt;
            e.data = m.data[63:0];
            e.en   = keep_en(m.en) & 6'h0f;
            e.last = (idx == RL - 1);
            row_cnt = (idx + 1) % RL;
            q.push_back(e);
        end else if (bus.row_clr) begin
            row_cnt = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;   bus.mode_sel = 2'd0;   bus.new_slot = '0;
        bus.row_clr = 1'b0;    bus.in_data = '0;      bus.out_ready = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.mode_sel = 2'd0; bus_a.new_slot = '0;
        bus_a.row_clr = 1'b0;  bus_a.in_data = '0;    bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.mode_sel = 2'd0; bus_b.new_slot = '0;
        bus_b.row_clr = 1'b0;  bus_b.in_data = '0;    bus_b.out_ready = 1'b1;
        bus_c.in_valid = 1'b0; bus_c.mode_sel = 2'd0; bus_c.new_slot = '0;
        bus_c.row_clr = 1'b0;  bus_c.in_data = '0;    bus_c.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data !== 64'h0) $display("FAIL rst_out_data: got %h want 0", bus.out_data); else n_pass++;
        n_total++; if (bus.out_last !== 1'b0 || en_main !== 4'h0)
            $display("FAIL rst_last_en: got last=%b en=%b want 0/0", bus.out_last, en_main); else n_pass++;
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_mapping();
        logic [1:0]  mode_tab [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
        logic        slot_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [63:0] data_tab [6] = '{64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001,
                                      64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001,
                                      64'h0004_0003_0002_0001, 64'hdead_beef_cafe_1234};
        exp_t e;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (c < 6);
            if (c < 6) begin
                bus.mode_sel = mode_tab[c]; bus.new_slot = slot_tab[c]; bus.in_data = data_tab[c];
            end
            if (bus.out_valid && bus.out_ready) begin
                n_total++;
                if (q.size() == 0) $display("FAIL map_extra: got data=%h, expected no beat", bus.out_data);
                else begin
                    e = q.pop_front();
                    if (bus.out_data !== e.data || bus.out_last !== e.last || en_main !== e.en)
                        $display("FAIL map_beat: got data=%h last=%b en=%b want data=%h last=%b en=%b",
                                 bus.out_data, bus.out_last, en_main, e.data, e.last, e.en);
                    else n_pass++;
                end
            end
            push_main();
        end
        n_total++; if (q.size() != 0) $display("FAIL map_drain: %0d beats left, want 0", q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic ready_tab [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int sent = 0, got = 0;
        logic held = 1'b0;
        logic [63:0] prev = '0;
        exp_t e;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (held) begin
                n_total++;
                if (bus.out_data !== prev) $display("FAIL bp_hold: got %h want %h", bus.out_data, prev); else n_pass++;
            end
            n_total++;
            if (bus.in_ready !== (q.size() < 2))
                $display("FAIL bp_in_ready: got %b want %b (held %0d)", bus.in_ready, q.size() < 2, q.size());
            else n_pass++;
            bus.out_ready = ready_tab[c];
            bus.in_valid  = (sent < 5);
            bus.mode_sel  = 2'd1;
            bus.in_data   = 64'h0004_0003_0002_0001 + 64'h0010_0010_0010_0010 * 64'(sent);
            held = bus.out_valid && !bus.out_ready;
            prev = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                n_total++; got++;
                if (q.size() == 0) $display("FAIL bp_extra: got data=%h, expected no beat", bus.out_data);
                else begin
                    e = q.pop_front();
                    if (bus.out_data !== e.data || bus.out_last !== e.last || en_main !== e.en)
                        $display("FAIL bp_beat: got data=%h last=%b want data=%h last=%b",
                                 bus.out_data, bus.out_last, e.data, e.last);
                    else n_pass++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                push_main();
                sent++;
            end
        end
        n_total++; if (got != 5 || q.size() != 0) $display("FAIL bp_count: got %0d beats, want 5", got); else n_pass++;
    endtask

    task automatic test_row();
        int sent = 0, got = 0;
        logic want_last;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.row_clr = 1'b1;
        push_main();
        for (int c = 0; c < 45 && got < 35; c++) begin
            @(negedge clk);
            bus.in_valid = (sent < 35);
            bus.row_clr  = (sent == 22) && (sent < 35);
            bus.mode_sel = 2'(sent % 4);
            bus.new_slot = sent[0];
            bus.in_data  = {4{sent[15:0]}};
            if (bus.out_valid && bus.out_ready) begin
                want_last = (got == 9 || got == 19 || got == 31);
                n_total++;
                if (bus.out_last !== want_last)
                    $display("FAIL row_last_beat%0d: got %b want %b", got, bus.out_last, want_last);
                else n_pass++;
                n_total++;
                if (q.size() == 0) $display("FAIL row_extra: got data=%h, expected no beat", bus.out_data);
                else begin
                    e = q.pop_front();
                    if (bus.out_data !== e.data || bus.out_last !== e.last || en_main !== e.en)
                        $display("FAIL row_beat%0d: got data=%h last=%b want data=%h last=%b",
                                 got, bus.out_data, bus.out_last, e.data, e.last);
                    else n_pass++;
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                push_main();
                sent++;
            end
        end
        bus.in_valid = 1'b0; bus.row_clr = 1'b0;
        n_total++; if (got != 35) $display("FAIL row_count: got %0d beats, want 35", got); else n_pass++;
    endtask

    task automatic test_async_reset();
        int got = 0, sent = 0;
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.mode_sel = 2'd1;
            bus.in_data = 64'h5555_6666_7777_8888;
            push_main();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b want 1", bus.out_valid); else n_pass++;
        @(posedge clk);
        #2 sys_rst = 1'b1;
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL ar_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL ar_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_data !== 64'h0 || bus.out_last !== 1'b0)
            $display("FAIL ar_out_data: got %h/%b want 0/0", bus.out_data, bus.out_last); else n_pass++;
        q.delete();
        row_cnt = 0;
        @(negedge clk);
        sys_rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 16 && got < 10; c++) begin
            @(negedge clk);
            bus.in_valid = (sent < 10); bus.mode_sel = 2'd2; bus.in_data = {4{sent[15:0] + 16'h0a00}};
            if (bus.out_valid && bus.out_ready) begin
                n_total++;
                if (q.size() == 0) $display("FAIL ar_extra: got data=%h, expected no beat", bus.out_data);
                else begin
                    e = q.pop_front();
                    if (bus.out_data !== e.data || bus.out_last !== e.last || bus.out_last !== (got == RL - 1))
                        $display("FAIL ar_beat%0d: got data=%h last=%b want data=%h last=%b",
                                 got, bus.out_data, bus.out_last, e.data, e.last);
                    else n_pass++;
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                push_main();
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        n_total++; if (got != 10) $display("FAIL ar_count: got %0d beats, want 10", got); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [1:0] mode_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic [1:0] slot_ab  [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
        logic [1:0] slot_c   [4] = '{2'd0, 2'd0, 2'd2, 2'd3};
        sexp_t s;
        model_t m;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus_a.in_valid = (c < 4); bus_b.in_valid = (c < 4); bus_c.in_valid = (c < 4);
            if (c < 4) begin
                bus_a.mode_sel = mode_tab[c]; bus_a.new_slot = slot_ab[c][0];
                bus_a.in_data  = 32'h0002_0001 + 32'h0100_0100 * 32'(c);
                bus_b.mode_sel = mode_tab[c]; bus_b.new_slot = slot_ab[c][0];
                bus_b.in_data  = 96'h0006_0005_0004_0003_0002_0001 + 96'h0100_0100_0100_0100_0100_0100 * 96'(c);
                bus_c.mode_sel = mode_tab[c]; bus_c.new_slot = slot_c[c];
                bus_c.in_data  = 64'h0004_0003_0002_0001 + 64'h0100_0100_0100_0100 * 64'(c);
            end
            if (bus_a.out_valid) begin
                n_total++;
                if (qa.size() == 0) $display("FAIL sw_a_extra: got %h, expected no beat", bus_a.out_data);
                else begin
                    s = qa.pop_front();
                    if (bus_a.out_data !== s.data[63:0] || en_a !== s.en[3:0])
                        $display("FAIL sw_a_x2: got data=%h en=%b want data=%h en=%b", bus_a.out_data, en_a, s.data[63:0], s.en[3:0]);
                    else n_pass++;
                end
            end
            if (bus_b.out_valid) begin
                n_total++;
                if (qb.size() == 0) $display("FAIL sw_b_extra: got %h, expected no beat", bus_b.out_data);
                else begin
                    s = qb.pop_front();
                    if (bus_b.out_data !== s.data[63:0] || en_b !== s.en[3:0])
                        $display("FAIL sw_b_x6: got data=%h en=%b want data=%h en=%b", bus_b.out_data, en_b, s.data[63:0], s.en[3:0]);
                    else n_pass++;
                end
            end
            if (bus_c.out_valid) begin
                n_total++;
                if (qc.size() == 0) $display("FAIL sw_c_extra: got %h, expected no beat", bus_c.out_data);
                else begin
                    s = qc.pop_front();
                    if (bus_c.out_data !== s.data || en_c !== s.en)
                        $display("FAIL sw_c_l6: got data=%h en=%b want data=%h en=%b", bus_c.out_data, en_c, s.data, s.en);
                    else n_pass++;
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                m = model_map(bus_a.mode_sel, int'(bus_a.new_slot), {64'b0, bus_a.in_data}, 2, 4);
                s.data = m.data; s.en = keep_en(m.en); qa.push_back(s);
            end
            if (bus_b.in_valid && bus_b.in_ready) begin
                m = model_map(bus_b.mode_sel, int'(bus_b.new_slot), bus_b.in_data, 6, 4);
                s.data = m.data; s.en = keep_en(m.en); qb.push_back(s);
            end
            if (bus_c.in_valid && bus_c.in_ready) begin
                m = model_map(bus_c.mode_sel, int'(bus_c.new_slot), {32'b0, bus_c.in_data}, 4, 6);
                s.data = m.data; s.en = keep_en(m.en); qc.push_back(s);
            end
        end
        n_total++;
        if (qa.size() + qb.size() + qc.size() != 0)
            $display("FAIL sw_drain: %0d beats left, want 0", qa.size() + qb.size() + qc.size());
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_mapping();
        test_backpressure();
        test_row();
        test_async_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
